// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver for the serial console path.
//
// Synchronises the asynchronous ser_rx line into the pll_clock domain, detects
// start bits, samples every bit at mid-period, checks the stop bit and
// presents each received byte on a valid/ready interface.
//
// Ports
//   pll_clock     in   system clock
//   reset         in   synchronous, active-high reset
//   ser_rx        in   asynchronous serial line, idle high
//   rx_data       out  received byte, stable while rx_valid is high
//   rx_valid      out  a byte is available
//   rx_ready      in   consumer accepts the byte when rx_valid && rx_ready
//   rx_frame_err  out  one-cycle pulse: stop bit sampled low
//   rx_overrun    out  one-cycle pulse: an unaccepted byte was overwritten
//   rx_busy       out  high in every state except IDLE
module uart_rx #(
  parameter int CLOCK_RATE = 48000000,
  parameter int BAUD_RATE  = 1000000
) (
  input  logic       pll_clock,
  input  logic       reset,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int CPB  = CLOCK_RATE / BAUD_RATE;
  localparam int HALF = CPB / 2;
  localparam int DW   = $clog2(CPB);

  localparam logic [DW-1:0] LOAD_HALF = DW'(HALF - 1);
  localparam logic [DW-1:0] LOAD_FULL = DW'(CPB - 1);

  generate
    if (CPB < 4) begin : g_cpb_check
      $error("uart_rx: CLOCK_RATE / BAUD_RATE must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t        state_q, state_d;
  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          deliver;

  always_ff @(posedge pll_clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      s1_q        <= 1'b1;
      s2_q        <= 1'b1;
      delay_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      delay_q     <= delay_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    s1_d        = ser_rx;
    s2_d        = s1_q;
    delay_d     = delay_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!s2_q) begin
          delay_d = LOAD_HALF;
          state_d = S_START;
        end
      end
      S_START: begin
        // Re-check the line half a bit in; a short low pulse is a glitch.
        if (delay_q != '0) begin
          delay_d = delay_q - 1'b1;
        end else if (!s2_q) begin
          delay_d   = LOAD_FULL;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (delay_q != '0) begin
          delay_d = delay_q - 1'b1;
        end else begin
          // LSB arrives first, so shift right and insert at the top.
          shift_d = {s2_q, shift_q[7:1]};
          delay_d = LOAD_FULL;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (delay_q != '0) begin
          delay_d = delay_q - 1'b1;
        end else if (s2_q) begin
          deliver = 1'b1;
          state_d = S_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        // A held-low line (break) must not be re-read as a stream of starts.
        if (s2_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    // A delivery wins over an acceptance in the same cycle; the old byte is
    // only lost (overrun) when the consumer did not take it in this cycle.
    if (deliver) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
      overrun_d  = rx_valid_q && !rx_ready;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = frame_err_q;
  assign rx_overrun   = overrun_q;
  assign rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx at 48 MHz / 1 Mbaud (CPB = 48).
// Every stimulus step starts 1 time unit after a rising edge, so the first
// edge that samples a new line level is the next rising edge.
module tb_uart_rx;

  localparam int CPB = 48;

  logic       pll_clock;
  logic       reset;
  logic       ser_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;

  int n_chk;
  int n_pass;

  // Monitor state: accepted bytes and pulse-cycle counts.
  logic [7:0] rx_log [0:63];
  int n_rx;
  int n_ferr;
  int n_ovr;

  uart_rx #(
    .CLOCK_RATE(48000000),
    .BAUD_RATE (1000000)
  ) dut (
    .pll_clock   (pll_clock),
    .reset       (reset),
    .ser_rx      (ser_rx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_frame_err(rx_frame_err),
    .rx_overrun  (rx_overrun),
    .rx_busy     (rx_busy)
  );

  initial pll_clock = 1'b0;
  always #5 pll_clock = ~pll_clock;

  initial begin
    n_rx   = 0;
    n_ferr = 0;
    n_ovr  = 0;
  end

  always @(negedge pll_clock) begin
    if (!reset) begin
      if (rx_valid && rx_ready) begin
        if (n_rx < 64) rx_log[n_rx] = rx_data;
        n_rx = n_rx + 1;
      end
      if (rx_frame_err) n_ferr = n_ferr + 1;
      if (rx_overrun) n_ovr = n_ovr + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    ser_rx = v;
    repeat (n) @(posedge pll_clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(b[i], CPB);
    drive_bit(stop, CPB);
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(posedge pll_clock);
    #1;
    rx_ready = 1'b0;
  endtask

  int rx0, fe0, ov0;
  logic [7:0] partial;

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    reset    = 1'b1;
    ser_rx   = 1'b1;
    rx_ready = 1'b0;
    repeat (3) @(posedge pll_clock);
    #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_busy", rx_busy, 0);
    chk("rst_ferr", rx_frame_err, 0);
    chk("rst_ovr", rx_overrun, 0);
    reset = 1'b0;
    drive_bit(1'b1, 5);

    // Single byte 0xA5, delivered at edge k+HALF+2+9*CPB = k+458.
    rx0 = n_rx;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (458) @(posedge pll_clock);
        #1;
        chk("a5_before", rx_valid, 0);
        @(posedge pll_clock);
        #1;
        chk("a5_rise", rx_valid, 1);
        chk("a5_data", rx_data, 8'hA5);
      end
    join
    drive_bit(1'b1, 100);
    chk("a5_hold_valid", rx_valid, 1);
    chk("a5_hold_data", rx_data, 8'hA5);
    pulse_ready();
    chk("a5_cleared", rx_valid, 0);
    chk("a5_accepts", n_rx - rx0, 1);
    chk("a5_logged", rx_log[rx0], 8'hA5);

    // Back-to-back bytes with no idle gap.
    rx_ready = 1'b1;
    rx0 = n_rx; fe0 = n_ferr; ov0 = n_ovr;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h55, 1'b1);
    drive_bit(1'b1, 10);
    chk("b2b_count", n_rx - rx0, 3);
    chk("b2b_byte0", rx_log[rx0], 8'h00);
    chk("b2b_byte1", rx_log[rx0+1], 8'hFF);
    chk("b2b_byte2", rx_log[rx0+2], 8'h55);
    chk("b2b_no_ovr", n_ovr - ov0, 0);
    chk("b2b_no_ferr", n_ferr - fe0, 0);

    // 10-cycle glitch: busy from k+2, back in IDLE after the k+26 check.
    rx0 = n_rx; fe0 = n_ferr;
    fork
      begin
        drive_bit(1'b0, 10);
        ser_rx = 1'b1;
      end
      begin
        repeat (11) @(posedge pll_clock);
        #1;
        chk("glitch_busy", rx_busy, 1);
        repeat (17) @(posedge pll_clock);
        #1;
        chk("glitch_idle", rx_busy, 0);
      end
    join
    drive_bit(1'b1, 2 * CPB);
    chk("glitch_no_byte", n_rx - rx0, 0);
    chk("glitch_no_ferr", n_ferr - fe0, 0);

    // Framing error, break held low, then recovery with 0x81.
    rx0 = n_rx; fe0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    drive_bit(1'b0, 200);
    chk("ferr_pulse_cycles", n_ferr - fe0, 1);
    chk("ferr_no_byte", n_rx - rx0, 0);
    chk("ferr_valid", rx_valid, 0);
    chk("ferr_wait_busy", rx_busy, 1);
    drive_bit(1'b1, 2 * CPB);
    chk("ferr_released", rx_busy, 0);
    send_frame(8'h81, 1'b1);
    drive_bit(1'b1, 10);
    chk("ferr_recover_count", n_rx - rx0, 1);
    chk("ferr_recover_byte", rx_log[rx0], 8'h81);
    chk("ferr_no_more", n_ferr - fe0, 1);

    // Overrun: second byte overwrites an unaccepted first byte.
    rx_ready = 1'b0;
    rx0 = n_rx; ov0 = n_ovr;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    drive_bit(1'b1, 10);
    chk("ovr_pulse_cycles", n_ovr - ov0, 1);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h22);
    pulse_ready();
    chk("ovr_accept", n_rx - rx0, 1);
    chk("ovr_accept_byte", rx_log[rx0], 8'h22);

    // Same pair, ready high only in the second delivery cycle (edge e0+939).
    rx0 = n_rx; ov0 = n_ovr;
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        repeat (480 + 458) @(posedge pll_clock);
        #1;
        rx_ready = 1'b1;
        @(posedge pll_clock);
        #1;
        rx_ready = 1'b0;
      end
    join
    drive_bit(1'b1, 10);
    chk("noovr_pulse", n_ovr - ov0, 0);
    chk("noovr_accept", n_rx - rx0, 1);
    chk("noovr_old_byte", rx_log[rx0], 8'h11);
    chk("noovr_valid", rx_valid, 1);
    chk("noovr_data", rx_data, 8'h22);
    pulse_ready();
    chk("noovr_cleared", rx_valid, 0);

    // Reset in the middle of data bit 4 of 0xC3.
    rx_ready = 1'b1;
    rx0 = n_rx; fe0 = n_ferr; ov0 = n_ovr;
    partial = 8'hC3;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(partial[i], CPB);
    drive_bit(partial[4], 10);
    chk("mid_busy_before", rx_busy, 1);
    reset  = 1'b1;
    ser_rx = 1'b1;
    @(posedge pll_clock);
    #1;
    chk("mid_rst_busy", rx_busy, 0);
    chk("mid_rst_valid", rx_valid, 0);
    chk("mid_rst_data", rx_data, 0);
    chk("mid_rst_ferr", rx_frame_err, 0);
    chk("mid_rst_ovr", rx_overrun, 0);
    repeat (2) @(posedge pll_clock);
    #1;
    reset = 1'b0;
    drive_bit(1'b1, 2 * CPB);
    send_frame(8'h7E, 1'b1);
    drive_bit(1'b1, 10);
    chk("mid_next_count", n_rx - rx0, 1);
    chk("mid_next_byte", rx_log[rx0], 8'h7E);
    chk("mid_no_ferr", n_ferr - fe0, 0);
    chk("mid_no_ovr", n_ovr - ov0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
